// File: rtl/div_radix2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_div_pkg
// Purpose  : Shared types and constants for the radix-2 restoring divider.
//            Operation and FSM state encodings, iteration count, and a small
//            helper that classifies signed operations.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rv_div_pkg;

  // Operand/result width; one quotient bit is produced per iteration.
  localparam int DIV_ITER = 32;

  // Low two bits of RV32M funct3 (100..111).
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // DIV and REM are the signed forms; they have bit 0 clear.
  function automatic logic is_signed_op(input logic [1:0] funct3);
    return ~funct3[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_radix2_if.sv
`default_nettype none
// ============================================================================
// Module   : div_radix2_if
// Purpose  : Request/response bundle between the execute stage and the
//            divider.
// Ports    : master drives enable_div, funct3, flush, dividend, divisor;
//            slave (divider) drives busy, div_o, div_finish.
// Revision : 1.0 - initial release
// ============================================================================
interface div_radix2_if
  import rv_div_pkg::*;
#(
  parameter int LENGTH = DIV_ITER
);
  logic              enable_div;
  logic [1:0]        funct3;
  logic              flush;
  logic [LENGTH-1:0] dividend;
  logic [LENGTH-1:0] divisor;
  logic              busy;
  logic [LENGTH-1:0] div_o;
  logic              div_finish;

  modport master (
    output enable_div, funct3, flush, dividend, divisor,
    input  busy, div_o, div_finish
  );

  modport slave (
    input  enable_div, funct3, flush, dividend, divisor,
    output busy, div_o, div_finish
  );
endinterface
`default_nettype wire

// File: rtl/div_radix2_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-division iteration.
// Ports    : rem_i     - current partial remainder
//            bit_i     - next dividend bit shifted into the remainder
//            divisor_i - divisor magnitude
//            rem_o     - updated partial remainder
//            qbit_o    - quotient bit produced by this iteration
// Revision : 1.0 - initial release
// ============================================================================
module div_step
  import rv_div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder is below 2*divisor, so a successful trial leaves a
  // difference that fits in WIDTH bits; the top bit is therefore a pure borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, divisor_i};
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule
`default_nettype wire

// File: rtl/div_radix2.sv
`default_nettype none
// ============================================================================
// Module   : div_radix2
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//            One quotient bit per clock; result returned with a one-cycle
//            finish pulse.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - div_radix2_if.slave (start/op/flush/operands in,
//                    busy/result/finish out)
// Revision : 1.0 - initial release
// ============================================================================
module div_radix2
  import rv_div_pkg::*;
#(
  parameter int LENGTH = DIV_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  div_radix2_if.slave bus
);
  localparam int            CW        = $clog2(LENGTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(LENGTH - 1);

  div_state_e        state_q;
  div_op_e           op_q;
  logic [CW-1:0]     count_q;
  logic [LENGTH-1:0] rem_q;   // partial remainder
  logic [LENGTH-1:0] quo_q;   // dividend bits shift out, quotient bits shift in
  logic [LENGTH-1:0] dsr_q;   // divisor magnitude
  logic [LENGTH-1:0] res_q;
  logic              qneg_q;
  logic              rneg_q;
  logic              busy_q;
  logic              fin_q;

  logic [LENGTH-1:0] step_rem;
  logic              step_qbit;

  div_step #(.WIDTH(LENGTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[LENGTH-1]),
    .divisor_i (dsr_q),
    .rem_o     (step_rem),
    .qbit_o    (step_qbit)
  );

  logic              a_neg;
  logic              b_neg;
  logic              div_zero;
  logic              ovf;
  logic [LENGTH-1:0] a_mag;
  logic [LENGTH-1:0] b_mag;
  logic [LENGTH-1:0] quo_fix;
  logic [LENGTH-1:0] rem_fix;
  logic [LENGTH-1:0] res_d;

  always_comb begin
    a_neg    = is_signed_op(bus.funct3) & bus.dividend[LENGTH-1];
    b_neg    = is_signed_op(bus.funct3) & bus.divisor[LENGTH-1];
    a_mag    = a_neg ? -bus.dividend : bus.dividend;
    b_mag    = b_neg ? -bus.divisor  : bus.divisor;
    div_zero = (bus.divisor == '0);
    ovf      = is_signed_op(bus.funct3)
             && (bus.dividend == {1'b1, {(LENGTH-1){1'b0}}})
             && (bus.divisor == '1);
    quo_fix  = qneg_q ? -quo_q : quo_q;
    rem_fix  = rneg_q ? -rem_q : rem_q;
    res_d    = op_q[1] ? rem_fix : quo_fix;
  end

  // Special cases preload quo_q/rem_q with the final answer and clear the
  // sign flags, so they share the FIX selection path with the normal case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= DIV;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      res_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enable_div && !bus.flush) begin
            op_q    <= div_op_e'(bus.funct3);
            dsr_q   <= b_mag;
            count_q <= '0;
            busy_q  <= 1'b1;
            if (div_zero) begin
              quo_q   <= '1;
              rem_q   <= bus.dividend;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= FIX;
            end else if (ovf) begin
              quo_q   <= bus.dividend;
              rem_q   <= '0;
              qneg_q  <= 1'b0;
              rneg_q  <= 1'b0;
              state_q <= FIX;
            end else begin
              quo_q   <= a_mag;
              rem_q   <= '0;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else begin
            rem_q   <= step_rem;
            quo_q   <= {quo_q[LENGTH-2:0], step_qbit};
            count_q <= count_q + 1'b1;
            if (count_q == LAST_STEP) begin
              count_q <= '0;
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          if (bus.flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            res_q   <= res_d;
            fin_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.div_o      = res_q;
  assign bus.div_finish = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_div_radix2.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_radix2
// Purpose  : Self-checking bench for div_radix2 with a result scoreboard.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_radix2;

  localparam logic [1:0] F_DIV  = 2'b00;
  localparam logic [1:0] F_DIVU = 2'b01;
  localparam logic [1:0] F_REM  = 2'b10;
  localparam logic [1:0] F_REMU = 2'b11;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          start;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;
  exp_t sb[$];

  div_radix2_if #(.LENGTH(32)) bus ();

  div_radix2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the divider signals completion.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.div_finish === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_finish: got div_o=0x%08h expected no finish", bus.div_o);
      end else begin
        e = sb.pop_front();
        if (bus.div_o !== e.exp) begin
          fails++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, bus.div_o, e.exp);
        end
        tests++;
        if (cyc - e.start != e.lat) begin
          fails++;
          $display("FAIL %s_latency: got %0d expected %0d", e.name, cyc - e.start, e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic issue(input string nm, input logic [1:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    bus.enable_div = 1'b1;
    bus.funct3     = f3;
    bus.dividend   = a;
    bus.divisor    = b;
    sb.push_back('{exp, lat, cyc + 1, nm});
  endtask

  // Waits for the scoreboard to drain, checking busy stays high meanwhile.
  task automatic wait_done(input string nm);
    int n   = 0;
    bit bad = 1'b0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (sb.size() != 0 && bus.busy !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s_busy: got busy low during op expected high", nm);
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no finish expected finish within 60 cycles", nm);
      sb.delete();
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    wait_idle();
    issue(nm, f3, a, b, exp, lat);
    @(negedge clk);
    bus.enable_div = 1'b0;
    wait_done(nm);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    bus.enable_div = 1'b0;
    bus.funct3     = 2'b00;
    bus.flush      = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, bus.busy},       32'd0);
    chk("rst_finish", {31'd0, bus.div_finish}, 32'd0);
    chk("rst_div_o",  bus.div_o,               32'd0);
    rst_n = 1'b1;

    // Unsigned and signed normal-path operations.
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2,  33);
    run_op("div_m100_7", F_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("rem_m100_7", F_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("div_100_m7", F_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run_op("rem_100_m7", F_REM,  32'd100, 32'hFFFF_FFF9, 32'd2, 33);
    run_op("div_m7_2",   F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

    // Divide by zero and signed overflow take the short path.
    run_op("divu_by0",  F_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",   F_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run_op("div_ovf",   F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_ovf",  F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("remu_ovf",  F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

    // Start held high through CALC with operands changing: single op only.
    wait_idle();
    issue("held_start", F_DIVU, 32'd100, 32'd7, 32'd14, 33);
    @(negedge clk);
    bus.dividend = 32'd0;
    bus.divisor  = 32'd1;
    repeat (19) @(negedge clk);
    bus.enable_div = 1'b0;
    wait_done("held_start");
    repeat (3) @(negedge clk);
    chk("held_no_requeue", {31'd0, bus.busy}, 32'd0);

    // Flush at cycle 10 of an op: no finish, busy drops, result kept.
    wait_idle();
    bus.enable_div = 1'b1;
    bus.funct3     = F_DIVU;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd3;
    @(negedge clk);
    bus.enable_div = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy",  {31'd0, bus.busy}, 32'd0);
    chk("flush_div_o", bus.div_o, 32'd14);
    repeat (40) @(negedge clk);
    chk("flush_div_o_late", bus.div_o, 32'd14);
    run_op("after_flush", F_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    // Flush together with a start in IDLE blocks the start.
    wait_idle();
    bus.enable_div = 1'b1;
    bus.flush      = 1'b1;
    bus.funct3     = F_DIVU;
    bus.dividend   = 32'd9;
    bus.divisor    = 32'd0;
    @(negedge clk);
    bus.enable_div = 1'b0;
    bus.flush      = 1'b0;
    chk("flush_start_blocked", {31'd0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_start_div_o", bus.div_o, 32'd333);

    // Asynchronous reset in the middle of CALC.
    wait_idle();
    bus.enable_div = 1'b1;
    bus.funct3     = F_DIVU;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    @(negedge clk);
    bus.enable_div = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   {31'd0, bus.busy},       32'd0);
    chk("midrst_finish", {31'd0, bus.div_finish}, 32'd0);
    chk("midrst_div_o",  bus.div_o,               32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", F_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
